// File: rtl/tattr_dma_pkg.sv
// Shared definitions for the tile-attribute DMA engine: register map,
// CTRL/STATUS bit positions and the transfer state encoding.
package tattr_dma_pkg;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int unsigned CTRL_START   = 0;
  localparam int unsigned CTRL_WAIT_VB = 1;
  localparam int unsigned CTRL_IRQ_EN  = 2;
  localparam int unsigned CTRL_CLEAR   = 3;
  localparam int unsigned CTRL_ABORT   = 4;

  localparam int unsigned STAT_BUSY   = 0;
  localparam int unsigned STAT_DONE   = 1;
  localparam int unsigned STAT_ERROR  = 2;
  localparam int unsigned STAT_IRQ_EN = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_VB,
    S_REQ,
    S_WAIT_DATA,
    S_WRITE,
    S_DONE
  } state_t;

endpackage

// File: rtl/tattr_dma.sv
// Copies a block of attribute bytes from 32-bit main memory into the video
// unit's tile attribute RAM, one byte per cycle, programmed via four MMIO registers.
module tattr_dma
  import tattr_dma_pkg::*;
#(
  parameter int unsigned TATTR_AW = 9,
  parameter int unsigned LEN_W    = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          reg_addr,
  input  logic [31:0]         reg_wdata,
  input  logic                reg_wenable,
  output logic [31:0]         reg_rdata,
  input  logic                vblank,
  output logic                mem_req,
  output logic [31:0]         mem_addr,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [31:0]         mem_rdata,
  output logic [TATTR_AW-1:0] tattr_addr,
  output logic [7:0]          tattr_wdata,
  output logic                tattr_wenable,
  output logic                irq
);

  localparam logic [LEN_W:0] MAX_LEN = {{LEN_W{1'b0}}, 1'b1} << TATTR_AW;

  state_t r_state, w_state_next;

  logic [31:0]         r_src, r_addr, r_word;
  logic [TATTR_AW-1:0] r_dst, r_idx;
  logic [LEN_W-1:0]    r_len, r_cnt;
  logic [1:0]          r_lane;
  logic                r_irq_en, r_done, r_error, r_abort_pend;

  logic w_busy, w_wr_ctrl, w_start, w_abort, w_clear;
  logic w_bad_cfg, w_len_zero, w_launch, w_last_byte, w_word_end;

  assign w_busy      = (r_state != S_IDLE);
  assign w_wr_ctrl   = reg_wenable && (reg_addr == REG_CTRL);
  assign w_start     = w_wr_ctrl && reg_wdata[CTRL_START] && !w_busy;
  assign w_abort     = w_wr_ctrl && reg_wdata[CTRL_ABORT];
  assign w_clear     = w_wr_ctrl && reg_wdata[CTRL_CLEAR];
  assign w_bad_cfg   = (r_src[1:0] != 2'b00) || ({1'b0, r_len} > MAX_LEN);
  assign w_len_zero  = (r_len == '0);
  assign w_launch    = w_start && !w_bad_cfg && !w_len_zero;
  assign w_last_byte = (r_cnt == LEN_W'(1));
  assign w_word_end  = w_last_byte || (r_lane == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:
        if (w_launch) w_state_next = reg_wdata[CTRL_WAIT_VB] ? S_WAIT_VB : S_REQ;
      S_WAIT_VB:
        if (w_abort)     w_state_next = S_IDLE;
        else if (vblank) w_state_next = S_REQ;
      // A grant coinciding with abort still owes us a response; it is absorbed in WAIT_DATA.
      S_REQ:
        if (mem_gnt)      w_state_next = S_WAIT_DATA;
        else if (w_abort) w_state_next = S_IDLE;
      S_WAIT_DATA:
        if (mem_rvalid) w_state_next = (w_abort || r_abort_pend) ? S_IDLE : S_WRITE;
      S_WRITE:
        if (w_abort)         w_state_next = S_IDLE;
        else if (w_word_end) w_state_next = w_last_byte ? S_DONE : S_REQ;
      S_DONE:
        w_state_next = S_IDLE;
      default:
        w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src        <= '0;
      r_dst        <= '0;
      r_len        <= '0;
      r_irq_en     <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_addr       <= '0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_word       <= '0;
      r_lane       <= '0;
      r_abort_pend <= 1'b0;
    end else begin
      if (reg_wenable && !w_busy) begin
        case (reg_addr)
          REG_SRC: r_src <= reg_wdata;
          REG_DST: r_dst <= reg_wdata[TATTR_AW-1:0];
          REG_LEN: r_len <= reg_wdata[LEN_W-1:0];
          default: ;
        endcase
      end
      if (w_wr_ctrl) r_irq_en <= reg_wdata[CTRL_IRQ_EN];
      // Clear is written before start so a combined write clears then starts.
      if (w_clear) begin
        r_done  <= 1'b0;
        r_error <= 1'b0;
      end
      if (w_start) begin
        if (w_bad_cfg) begin
          r_error <= 1'b1;
        end else if (w_len_zero) begin
          r_done <= 1'b1;
        end else begin
          r_done  <= 1'b0;
          r_error <= 1'b0;
          r_addr  <= r_src;
          r_idx   <= r_dst;
          r_cnt   <= r_len;
        end
      end
      case (r_state)
        S_IDLE: r_abort_pend <= 1'b0;
        S_REQ:
          if (mem_gnt && w_abort) r_abort_pend <= 1'b1;
        S_WAIT_DATA:
          if (mem_rvalid) begin
            r_word       <= mem_rdata;
            r_lane       <= 2'd0;
            r_addr       <= r_addr + 32'd4;
            r_abort_pend <= 1'b0;
          end else if (w_abort) begin
            r_abort_pend <= 1'b1;
          end
        S_WRITE:
          if (!w_abort) begin
            r_idx  <= r_idx + TATTR_AW'(1);
            r_cnt  <= r_cnt - LEN_W'(1);
            r_lane <= r_lane + 2'd1;
          end
        S_DONE: r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  assign mem_req       = (r_state == S_REQ);
  assign mem_addr      = r_addr;
  assign tattr_wenable = (r_state == S_WRITE);
  assign tattr_addr    = r_idx;
  assign tattr_wdata   = r_word[{r_lane, 3'b000} +: 8];
  assign irq           = r_done & r_irq_en;

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      REG_SRC: reg_rdata = r_src;
      REG_DST: reg_rdata[TATTR_AW-1:0] = r_dst;
      REG_LEN: reg_rdata[LEN_W-1:0] = r_len;
      default: begin
        reg_rdata[STAT_BUSY]   = w_busy;
        reg_rdata[STAT_DONE]   = r_done;
        reg_rdata[STAT_ERROR]  = r_error;
        reg_rdata[STAT_IRQ_EN] = r_irq_en;
      end
    endcase
  end

endmodule

// File: tb/tb_tattr_dma.sv
// Directed bench for tattr_dma: a behavioural memory whose byte at address a
// is a[7:0], plus a log of every attribute write for comparison.
module tb_tattr_dma;
  import tattr_dma_pkg::*;

  localparam int unsigned AW = 9;
  localparam int unsigned LW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    reg_addr = '0;
  logic [31:0]   reg_wdata = '0;
  logic          reg_wenable = 1'b0;
  logic [31:0]   reg_rdata;
  logic          vblank = 1'b0;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [31:0]   mem_rdata = '0;
  logic [AW-1:0] tattr_addr;
  logic [7:0]    tattr_wdata;
  logic          tattr_wenable;
  logic          irq;

  always #5 clk = ~clk;

  tattr_dma #(.TATTR_AW(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wenable(reg_wenable),
    .reg_rdata(reg_rdata), .vblank(vblank),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .tattr_addr(tattr_addr), .tattr_wdata(tattr_wdata),
    .tattr_wenable(tattr_wenable), .irq(irq)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] word_at(logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  // Memory responder: grants after gnt_delay cycles of request, data latency cycles later.
  int gnt_delay = 0;
  int latency = 1;
  int wait_cnt = 0;
  int lat_cnt = 0;
  bit pending = 1'b0;
  logic [31:0] raddr = '0;

  always @(negedge clk) begin
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    if (!rst_n) begin
      pending = 1'b0;
      wait_cnt = 0;
    end else if (pending) begin
      if (lat_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata = word_at(raddr);
        pending = 1'b0;
      end else begin
        lat_cnt--;
      end
    end else if (mem_req) begin
      if (wait_cnt >= gnt_delay) begin
        mem_gnt = 1'b1;
        pending = 1'b1;
        lat_cnt = latency - 1;
        wait_cnt = 0;
        raddr = mem_addr;
      end else begin
        wait_cnt++;
      end
    end
  end

  int log_idx[$];
  int log_dat[$];
  int log_cyc[$];

  always @(negedge clk) begin
    if (rst_n && tattr_wenable) begin
      log_idx.push_back(int'(tattr_addr));
      log_dat.push_back(int'(tattr_wdata));
      log_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
    reg_addr = a;
    reg_wdata = d;
    reg_wenable = 1'b1;
    @(negedge clk);
    reg_wenable = 1'b0;
  endtask

  task automatic reg_rd(input logic [1:0] a, output logic [31:0] d);
    reg_addr = a;
    #1 d = reg_rdata;
  endtask

  task automatic wait_idle(input int max_cycles);
    logic [31:0] s;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      reg_rd(REG_CTRL, s);
      if (!s[STAT_BUSY]) return;
    end
    check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic clear_log();
    log_idx.delete();
    log_dat.delete();
    log_cyc.delete();
  endtask

  task automatic check_log(input string tag, input int n, input int first_idx, input int first_dat);
    check({tag, "_count"}, log_idx.size(), n);
    for (int i = 0; i < n && i < log_idx.size(); i++) begin
      check({tag, "_idx"}, log_idx[i], (first_idx + i) % 512);
      check({tag, "_dat"}, log_dat[i], (first_dat + i) % 256);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] s;
    int k;
    int hi;
    int t1_off[8];
    bit seen;
    t1_off = '{2, 3, 4, 5, 8, 9, 10, 11};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_tattr_we", tattr_wenable, 0);
    check("rst_tattr_addr", tattr_addr, 0);
    check("rst_irq", irq, 0);
    reg_rd(REG_CTRL, s);
    check("rst_status", s, 0);

    // Basic 8-byte copy with irq enabled, cycle-exact
    reg_wr(REG_SRC, 32'h100);
    reg_wr(REG_DST, 32'd0);
    reg_wr(REG_LEN, 32'd8);
    clear_log();
    reg_wr(REG_CTRL, 32'h5);
    k = cyc;
    check("t1_req_rise", mem_req, 1);
    check("t1_mem_addr", mem_addr, 32'h100);
    repeat (12) @(negedge clk);
    reg_rd(REG_CTRL, s);
    check("t1_status_done_state", s, 32'h9);
    check("t1_irq_early", irq, 0);
    @(negedge clk);
    reg_rd(REG_CTRL, s);
    check("t1_status_final", s, 32'hA);
    check("t1_irq", irq, 1);
    check_log("t1", 8, 0, 0);
    for (int i = 0; i < 8 && i < log_cyc.size(); i++)
      check("t1_write_cycle", log_cyc[i] - k, t1_off[i]);

    // Index wrap and partial final word
    reg_wr(REG_SRC, 32'h200);
    reg_wr(REG_DST, 32'd510);
    reg_wr(REG_LEN, 32'd6);
    clear_log();
    reg_wr(REG_CTRL, 32'h1);
    wait_idle(100);
    check_log("t2", 6, 510, 0);
    reg_rd(REG_CTRL, s);
    check("t2_status", s, 32'h2);
    check("t2_irq_off", irq, 0);

    // Hold for vertical blanking
    reg_wr(REG_SRC, 32'h100);
    reg_wr(REG_DST, 32'h10);
    reg_wr(REG_LEN, 32'd4);
    clear_log();
    reg_wr(REG_CTRL, 32'h3);
    hi = 0;
    repeat (50) begin
      if (mem_req) hi++;
      @(negedge clk);
    end
    check("t3_req_held_off", hi, 0);
    vblank = 1'b1;
    check("t3_req_before_vb", mem_req, 0);
    @(negedge clk);
    check("t3_req_after_vb", mem_req, 1);
    vblank = 1'b0;
    wait_idle(100);
    check_log("t3", 4, 16, 0);

    // Start-time rejections and zero length
    reg_wr(REG_SRC, 32'h102);
    reg_wr(REG_LEN, 32'd4);
    reg_wr(REG_CTRL, 32'h9);
    check("t4_misalign_req", mem_req, 0);
    reg_rd(REG_CTRL, s);
    check("t4_misalign_status", s, 32'h4);
    reg_wr(REG_SRC, 32'h100);
    reg_wr(REG_LEN, 32'd513);
    reg_rd(REG_LEN, s);
    check("t4_len_readback", s, 32'd513);
    reg_wr(REG_CTRL, 32'h9);
    check("t4_toolong_req", mem_req, 0);
    reg_rd(REG_CTRL, s);
    check("t4_toolong_status", s, 32'h4);
    reg_wr(REG_LEN, 32'd0);
    reg_wr(REG_CTRL, 32'h9);
    hi = 0;
    repeat (5) begin
      if (mem_req) hi++;
      @(negedge clk);
    end
    check("t4_zero_no_req", hi, 0);
    reg_rd(REG_CTRL, s);
    check("t4_zero_status", s, 32'h2);

    // Largest legal length fills the whole RAM
    reg_wr(REG_DST, 32'd0);
    reg_wr(REG_LEN, 32'd512);
    clear_log();
    reg_wr(REG_CTRL, 32'h9);
    wait_idle(2000);
    check("t4_max_count", log_idx.size(), 512);
    reg_rd(REG_CTRL, s);
    check("t4_max_status", s, 32'h2);
    if (log_idx.size() == 512) begin
      check("t4_max_last_idx", log_idx[511], 511);
      check("t4_max_last_dat", log_dat[511], 8'hFF);
    end

    // Abort while a read is outstanding, then restart
    latency = 6;
    reg_wr(REG_LEN, 32'd8);
    clear_log();
    reg_wr(REG_CTRL, 32'h9);
    @(negedge clk);
    reg_wr(REG_CTRL, 32'h10);
    repeat (10) @(negedge clk);
    check("t5_no_writes", log_idx.size(), 0);
    reg_rd(REG_CTRL, s);
    check("t5_status", s, 32'h0);
    latency = 1;
    reg_wr(REG_CTRL, 32'h1);
    wait_idle(100);
    check_log("t5_restart", 8, 0, 0);
    reg_rd(REG_CTRL, s);
    check("t5_restart_status", s, 32'h2);

    // Grant withheld, then reset in the middle of byte writes
    gnt_delay = 10;
    reg_wr(REG_SRC, 32'h140);
    reg_wr(REG_DST, 32'h20);
    clear_log();
    reg_wr(REG_CTRL, 32'h1);
    for (int i = 0; i < 10; i++) begin
      check("t6_req_held", mem_req, 1);
      check("t6_addr_stable", mem_addr, 32'h140);
      @(negedge clk);
    end
    gnt_delay = 0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (tattr_wenable) seen = 1'b1;
      else @(negedge clk);
    end
    check("t6_write_seen", seen, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_mem_req", mem_req, 0);
    check("t6_rst_mem_addr", mem_addr, 0);
    check("t6_rst_tattr_we", tattr_wenable, 0);
    check("t6_rst_tattr_addr", tattr_addr, 0);
    check("t6_rst_tattr_wdata", tattr_wdata, 0);
    check("t6_rst_irq", irq, 0);
    reg_rd(REG_CTRL, s);
    check("t6_rst_status", s, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    reg_rd(REG_SRC, s);
    check("t6_rst_src", s, 0);
    check("t6_post_rst_req", mem_req, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
